// File: rtl/keypad_pkg.sv
// Shared types, key map and defaults for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned SCAN_DIV_DEF     = 100000;
  localparam int unsigned DEBOUNCE_CNT_DEF = 4;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_e;

  // Indexed by {row, col}; entry 0 is row 0 / column 0.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic single_low(input logic [3:0] rows);
    return ($countones(~rows) == 1);
  endfunction

  function automatic logic [1:0] low_row(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_row_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad rows.
module row_sync (
  input  logic       CLK,
  input  logic       clr,
  input  logic [3:0] row_in,
  output logic [3:0] row_s
);

  logic [3:0] meta_q, meta_d;
  logic [3:0] sync_q, sync_d;

  always_comb begin
    meta_d = row_in;
    sync_d = meta_q;
  end

  always_ff @(posedge CLK) begin
    if (clr) begin
      meta_q <= 4'b1111;
      sync_q <= 4'b1111;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign row_s = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad column scanner with press/release debounce and a 4-key history.
//   state       | meaning
//   ST_SCAN     | rotating columns, waiting for exactly one row low
//   ST_DEBOUNCE | column frozen, counting samples that match the latched rows
//   ST_HELD     | key reported, waiting for all rows released
//   ST_RELEASE  | counting all-high samples before resuming the scan
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = SCAN_DIV_DEF,
  parameter int unsigned DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
) (
  input  logic        CLK,
  input  logic        clr,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] disp_data
);

  localparam int unsigned DW = cnt_w(SCAN_DIV);
  localparam int unsigned MW = cnt_w(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(DEBOUNCE_CNT - 1);

  logic [3:0]    row_s;
  logic          sample;
  logic [3:0]    key_code_new;

  state_e        state_q, state_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    col_out_q, col_out_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [MW-1:0] match_q, match_d;
  logic [3:0]    row_lat_q, row_lat_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;
  logic [15:0]   disp_q, disp_d;

  row_sync u_row_sync (
    .CLK    (CLK),
    .clr    (clr),
    .row_in (row_in),
    .row_s  (row_s)
  );

  always_comb begin
    sample       = (dwell_q == DWELL_LAST);
    dwell_d      = sample ? '0 : dwell_q + 1'b1;
    key_code_new = KEY_MAP[{low_row(row_lat_q), col_q}];

    state_d     = state_q;
    col_d       = col_q;
    match_d     = match_q;
    row_lat_d   = row_lat_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    disp_d      = disp_q;

    if (sample) begin
      case (state_q)
        ST_SCAN: begin
          if (single_low(row_s)) begin
            row_lat_d = row_s;
            match_d   = '0;
            state_d   = ST_DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (row_s == row_lat_q) begin
            if (match_q == MATCH_LAST) begin
              key_valid_d = 1'b1;
              key_code_d  = key_code_new;
              disp_d      = {disp_q[11:0], key_code_new};
              key_held_d  = 1'b1;
              match_d     = '0;
              state_d     = ST_HELD;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            col_d   = col_q + 2'd1;
            state_d = ST_SCAN;
          end
        end
        ST_HELD: begin
          // Anything but all-high keeps us here, including extra rows.
          if (row_s == 4'b1111) begin
            match_d = '0;
            state_d = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (row_s == 4'b1111) begin
            if (match_q == MATCH_LAST) begin
              key_held_d = 1'b0;
              match_d    = '0;
              col_d      = col_q + 2'd1;
              state_d    = ST_SCAN;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            state_d = ST_HELD;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end

    col_out_d = ~(4'b0001 << col_d);
  end

  always_ff @(posedge CLK) begin
    if (clr) begin
      state_q     <= ST_SCAN;
      col_q       <= 2'd0;
      col_out_q   <= 4'b1110;
      dwell_q     <= '0;
      match_q     <= '0;
      row_lat_q   <= 4'b1111;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      disp_q      <= 16'h0000;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      col_out_q   <= col_out_d;
      dwell_q     <= dwell_d;
      match_q     <= match_d;
      row_lat_q   <= row_lat_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      disp_q      <= disp_d;
    end
  end

  assign col_out   = col_out_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign disp_data = disp_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a switch-matrix model drives row_in from col_out and a
// key-history model predicts code, display and pulse counts per keystroke.
module tb_keypad_scan;

  localparam int S           = 4;
  localparam int D           = 2;
  localparam int PRESS_BOUND = (D + 4) * S + 3;
  localparam int REL_BOUND   = (D + 1) * S + 3;

  typedef struct {
    int         row;
    int         col;
    logic [3:0] code;
  } vec_t;

  logic        CLK = 1'b0;
  logic        clr;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] disp_data;

  logic [15:0] pressed = '0;
  logic [15:0] model_disp = '0;
  vec_t        vec [16];
  int          checks = 0;
  int          errors = 0;
  int          pulse_cnt = 0;
  int          bad_col = 0;
  bit          mon_on = 0;

  keypad_scan #(.SCAN_DIV(S), .DEBOUNCE_CNT(D)) dut (
    .CLK       (CLK),
    .clr       (clr),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .disp_data (disp_data)
  );

  always #5 CLK = ~CLK;

  // A pressed switch pulls its row low only while its column is driven low.
  always_comb begin
    row_in = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && col_out[c] === 1'b0) row_in[r] = 1'b0;
  end

  initial forever begin
    @(negedge CLK);
    if (mon_on) begin
      if (key_valid === 1'b1) pulse_cnt++;
      if ($isunknown(col_out) || $countones(~col_out) != 1) bad_col++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    pressed = '0;
    clr = 1'b1;
    tick(3);
    clr = 1'b0;
    model_disp = '0;
  endtask

  task automatic wait_pulse(input string name, output bit seen);
    int i;
    seen = 0;
    i = 0;
    while (!seen && i < PRESS_BOUND) begin
      tick(1);
      i++;
      if (key_valid === 1'b1) seen = 1;
    end
    check({name, " pulse_within_bound"}, 32'(seen), 32'd1);
  endtask

  task automatic release_keys(input string name);
    int i;
    pressed = '0;
    tick(D * S + 2);
    check({name, " held_min"}, 32'(key_held), 32'd1);
    i = D * S + 2;
    while (key_held !== 1'b0 && i < REL_BOUND) begin
      tick(1);
      i++;
    end
    check({name, " held_drop"}, 32'(key_held), 32'd0);
  endtask

  task automatic press_key(input vec_t v, input int hold, input bit extra);
    int    p0;
    bit    seen;
    string nm;
    nm = $sformatf("key_%h", v.code);
    p0 = pulse_cnt;
    pressed[v.row*4+v.col] = 1'b1;
    wait_pulse(nm, seen);
    if (seen) begin
      model_disp = {model_disp[11:0], v.code};
      check({nm, " key_code"}, 32'(key_code), 32'(v.code));
      check({nm, " disp_data"}, 32'(disp_data), 32'(model_disp));
      check({nm, " held_on"}, 32'(key_held), 32'd1);
    end
    if (extra) pressed[((v.row + 1) % 4)*4 + v.col] = 1'b1;
    tick(hold + 1);
    check({nm, " single_pulse"}, 32'(pulse_cnt - p0), 32'd1);
    release_keys(nm);
    check({nm, " no_release_pulse"}, 32'(pulse_cnt - p0), 32'd1);
  endtask

  initial begin
    logic [3:0] codes [16];
    int         p0;
    int         idx;
    int         len;
    bit         seen;

    codes = '{4'h1, 4'h2, 4'h3, 4'hA,
              4'h4, 4'h5, 4'h6, 4'hB,
              4'h7, 4'h8, 4'h9, 4'hC,
              4'hE, 4'h0, 4'hF, 4'hD};
    for (int i = 0; i < 16; i++) begin
      vec[i].row  = i / 4;
      vec[i].col  = i % 4;
      vec[i].code = codes[i];
    end

    // Reset values and column rotation.
    do_reset();
    mon_on = 1;
    check("rst col_out", 32'(col_out), 32'h0000000E);
    check("rst disp_data", 32'(disp_data), 32'h0);
    check("rst key_valid", 32'(key_valid), 32'h0);
    check("rst key_held", 32'(key_held), 32'h0);
    check("rst key_code", 32'(key_code), 32'h0);
    tick(3);
    check("rot dwell_end", 32'(col_out), 32'h0000000E);
    tick(1);
    check("rot col1", 32'(col_out), 32'h0000000D);
    tick(4);
    check("rot col2", 32'(col_out), 32'h0000000B);
    tick(4);
    check("rot col3", 32'(col_out), 32'h00000007);
    tick(4);
    check("rot wrap", 32'(col_out), 32'h0000000E);

    // '5' held for 200 cycles.
    do_reset();
    press_key(vec[5], 200, 0);
    check("key5 disp", 32'(disp_data), 32'h00000005);

    // Sequence 1,2,3,A,7.
    do_reset();
    p0 = pulse_cnt;
    press_key(vec[0], 20, 0);
    press_key(vec[1], 20, 0);
    press_key(vec[2], 20, 0);
    press_key(vec[3], 20, 0);
    press_key(vec[8], 20, 0);
    check("seq disp", 32'(disp_data), 32'h000023A7);
    check("seq pulses", 32'(pulse_cnt - p0), 32'd5);

    // Every key of the map.
    for (int i = 0; i < 16; i++) press_key(vec[i], 10, 0);
    check("map disp", 32'(disp_data), 32'h0000E0FD);

    // Bounce: row1 low for a single sample in column 1.
    do_reset();
    p0 = pulse_cnt;
    tick(4);
    check("bounce col1", 32'(col_out), 32'h0000000D);
    pressed[5] = 1'b1;
    tick(4);
    check("bounce col_frozen", 32'(col_out), 32'h0000000D);
    pressed[5] = 1'b0;
    tick(4);
    check("bounce next_col", 32'(col_out), 32'h0000000B);
    tick(4 * S);
    check("bounce no_pulse", 32'(pulse_cnt - p0), 32'd0);
    check("bounce no_held", 32'(key_held), 32'd0);

    // Two rows low in column 0.
    do_reset();
    p0 = pulse_cnt;
    pressed[0] = 1'b1;
    pressed[8] = 1'b1;
    tick(4);
    check("dual col_advance", 32'(col_out), 32'h0000000D);
    tick(60);
    check("dual no_pulse", 32'(pulse_cnt - p0), 32'd0);
    check("dual no_held", 32'(key_held), 32'd0);
    pressed = '0;
    tick(4);
    press_key(vec[1], 10, 0);
    check("dual then 2 disp", 32'(disp_data), 32'h00000002);

    // clr while 'D' is held, then re-detection.
    do_reset();
    p0 = pulse_cnt;
    pressed[15] = 1'b1;
    wait_pulse("keyD first", seen);
    tick(20);
    check("keyD held", 32'(key_held), 32'd1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    model_disp = '0;
    check("clr col_out", 32'(col_out), 32'h0000000E);
    check("clr key_held", 32'(key_held), 32'd0);
    check("clr key_code", 32'(key_code), 32'd0);
    check("clr disp", 32'(disp_data), 32'd0);
    check("clr key_valid", 32'(key_valid), 32'd0);
    wait_pulse("keyD again", seen);
    check("keyD again code", 32'(key_code), 32'h0000000D);
    check("keyD again disp", 32'(disp_data), 32'h0000000D);
    release_keys("keyD");
    check("keyD pulses", 32'(pulse_cnt - p0), 32'd2);

    // Random keystrokes, extra rows while held, and short glitches.
    do_reset();
    for (int n = 0; n < 30; n++) begin
      idx = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) begin
        p0 = pulse_cnt;
        len = $urandom_range(1, S - 1);
        pressed[vec[idx].row*4+vec[idx].col] = 1'b1;
        tick(len);
        pressed = '0;
        tick(3 * S);
        check("glitch no_pulse", 32'(pulse_cnt - p0), 32'd0);
      end else begin
        press_key(vec[idx], $urandom_range(0, 60), 1'($urandom_range(0, 1)));
      end
      tick($urandom_range(0, 2 * S));
    end
    check("rand disp", 32'(disp_data), 32'(model_disp));
    check("col_out one_low", 32'(bad_col), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, meaning CLK cycles each column is driven before its rows are sampled (1 ms at 100 MHz).
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 4, meaning the number of consecutive identical samples that confirms a press or a release.
REQ-003 SHALL have port CLK  input  1  system clock; the only clock, all logic on its rising edge.
REQ-004 SHALL have port clr  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port row_in  input  4  keypad rows; active-low, pulled up, asynchronous to CLK.
REQ-006 SHALL have port col_out  output  4  keypad column drive; exactly one bit low, others high.
REQ-007 SHALL have port key_code  output  4  hex value of the last confirmed key.
REQ-008 SHALL have port key_valid  output  1  one-cycle pulse on each confirmed press.
REQ-009 SHALL have port key_held  output  1  high while a confirmed key remains pressed.
REQ-010 SHALL have port disp_data  output  16  last four keys entered, newest in [3:0]; feeds the 7-segment display driver directly.

Function
REQ-011 SHALL pass row_in through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-012 SHALL keep a dwell counter 0..SCAN_DIV-1; a "sample" is the synchronized row value taken when dwell = SCAN_DIV-1; dwell then wraps to 0.
REQ-013 SHALL implement states SCAN, DEBOUNCE, HELD, RELEASE.
REQ-014 In SCAN, on a sample with exactly one row low: latch (column, row), clear the match counter, go to DEBOUNCE, and keep the current column driven.
REQ-015 In SCAN, on a sample of 4'b1111 or with two or more rows low: advance the column 0->1->2->3->0 (col_out 1110->1101->1011->0111->1110) and stay in SCAN.
REQ-016 In DEBOUNCE, on a sample equal to the latched row pattern: increment the match counter. On the sample that brings it to DEBOUNCE_CNT, the next cycle SHALL drive key_valid=1 for exactly one cycle, update key_code, set disp_data <= {disp_data[11:0], key_code_new}, set key_held=1, and go to HELD.
REQ-017 In DEBOUNCE, on any differing sample: return to SCAN, advance the column, and emit no key_valid.
REQ-018 In HELD, on a sample of 4'b1111: go to RELEASE with the counter cleared. On any other sample: stay in HELD. Extra rows low SHALL be ignored; no new key is reported.
REQ-019 In RELEASE, on each sample of 4'b1111: increment the counter. At DEBOUNCE_CNT: clear key_held, advance the column, and go to SCAN. On any non-1111 sample: return to HELD with no new key_valid.
REQ-020 SHALL map keys as: row0 1 2 3 A; row1 4 5 6 B; row2 7 8 9 C; row3 E 0 F D (columns 0..3).
REQ-021 Key repeat SHALL NOT occur; one press yields one key_valid regardless of hold time.
REQ-022 Counter widths SHALL be sized from the parameters, with no wrap-around before the terminal counts.
REQ-023 Worst-case press-to-key_valid latency SHALL be (DEBOUNCE_CNT+4)*SCAN_DIV+3 cycles.

Reset
REQ-024 When clr=1 at a rising edge, the following SHALL take effect on the next cycle: state=SCAN, column=0, col_out=4'b1110, dwell=0, counters=0, synchronizer=4'b1111, key_code=0, key_valid=0, key_held=0, disp_data=16'h0000.
REQ-025 clr SHALL take priority over all state transitions. A clr during DEBOUNCE or HELD SHALL suppress any pending key_valid. A key still pressed after clr SHALL be re-detected and reported normally.

Structure
REQ-026 Package keypad_pkg SHALL hold the state encoding, the 16-entry key map constant, and the default SCAN_DIV/DEBOUNCE_CNT values.
REQ-027 The 2-flop synchronizer SHALL be a sub-module named row_sync (4 bits wide, reset value 4'b1111).

Verification (SCAN_DIV=4, DEBOUNCE_CNT=2)
REQ-028 Reset: hold clr for 3 cycles, row_in=1111 -> col_out=1110, disp_data=0000, key_valid=0; col_out then rotates every 4 cycles.
REQ-029 Press '5' (row1 low only when col_out=1101), held 200 cycles -> exactly one key_valid, key_code=5, disp_data=0005, key_held high until 2 samples after release.
REQ-030 Sequence 1,2,3,A,7 with clean presses/releases -> disp_data=23A7 after the fifth pulse, five key_valid pulses total.
REQ-031 Bounce: row1 low for one sample then high -> no key_valid, state returns to SCAN, scanning resumes at the next column.
REQ-032 Two rows low in the same column (rows 0 and 2, col 0) -> no key_valid, scan continues; a single-row press afterwards is reported normally.
REQ-033 clr asserted in HELD with key 'D' still pressed -> outputs reset on the next cycle; 'D' reported again after re-debounce, disp_data=000D.
